tlc_signal_monitor: RTL

Passive checker at the receiving end of the traffic-light controller's signal-head buses. It samples the four 3-bit light outputs (L2R, D2R, L2D, R2LandR2D) and decodes each into a per-approach phase tracker. It enforces encoding, sequence, dwell-time, starvation and conflict rules, and reports sticky error flags, a decoded green mask and a completed-cycle count. It sits beside the controller in integration benches and on silicon as a safety monitor; it drives nothing back into the controller.

---
 rtl/tlc_signal_monitor.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tlc_signal_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tlc_signal_monitor
// Description : Passive safety monitor for the traffic-light controller's
//               signal-head buses. It samples the four 3-bit light buses and
//               runs a phase tracker for each approach. It reports sticky
//               encoding, sequence, dwell, starvation and conflict errors, a
//               decoded green mask and a count of completed cycles.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous reset, active low
//   L2R          in   3  light bus, approach 0, {red, yellow, green}
//   D2R          in   3  light bus, approach 1
//   L2D          in   3  light bus, approach 2
//   R2LandR2D    in   3  light bus, approach 3
//   clr_err      in   1  synchronous clear of all sticky error flags
//   green_mask   out  4  bit i = approach i sampled green
//   err_enc      out  4  sticky, illegal encoding on approach i
//   err_seq      out  4  sticky, illegal transition on approach i
//   err_dwell    out  4  sticky, short green / wrong yellow on approach i
//   err_starve   out  4  sticky, red held longer than MAX_RED on approach i
//   err_conflict out  1  sticky, conflicting approaches active together
//   err_any      out  1  OR of all error flags
//   cycle_cnt    out  8  approach-3 yellow->red transitions, wrapping
// ============================================================================
module tlc_signal_monitor #(
  parameter int MIN_GREEN = 5,
  parameter int YEL_CYC   = 2,
  parameter int MAX_RED   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] L2R,
  input  logic [2:0] D2R,
  input  logic [2:0] L2D,
  input  logic [2:0] R2LandR2D,
  input  logic       clr_err,
  output logic [3:0] green_mask,
  output logic [3:0] err_enc,
  output logic [3:0] err_seq,
  output logic [3:0] err_dwell,
  output logic [3:0] err_starve,
  output logic       err_conflict,
  output logic       err_any,
  output logic [7:0] cycle_cnt
);

  localparam int N_APP = 4;

  // Legal one-hot light encodings {red, yellow, green}
  localparam logic [2:0] ENC_RED = 3'b100;
  localparam logic [2:0] ENC_YEL = 3'b010;
  localparam logic [2:0] ENC_GRN = 3'b001;

  // Tracker states
  localparam logic [1:0] ST_UNK = 2'd0;
  localparam logic [1:0] ST_GRN = 2'd1;
  localparam logic [1:0] ST_YEL = 2'd2;
  localparam logic [1:0] ST_RED = 2'd3;

  localparam logic [5:0] DWELL_SAT   = 6'd63;
  localparam logic [6:0] MIN_GREEN_C = 7'(MIN_GREEN);
  localparam logic [6:0] YEL_CYC_C   = 7'(YEL_CYC);
  localparam logic [6:0] STARVE_AT_C = 7'(MAX_RED + 1);

  // --------------------------------------------------------------------------
  // Sampling stage
  // --------------------------------------------------------------------------
  logic [N_APP-1:0][2:0] bus_w;
  logic [N_APP-1:0][2:0] samp_q;
  logic                  samp_vld_q;

  assign bus_w = {R2LandR2D, L2D, D2R, L2R};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_q     <= '0;
      samp_vld_q <= 1'b0;
    end else begin
      samp_q     <= bus_w;
      samp_vld_q <= 1'b1;
    end
  end

  // Per-approach events for the current sample
  logic [N_APP-1:0] enc_ev_w;
  logic [N_APP-1:0] seq_ev_w;
  logic [N_APP-1:0] dwell_ev_w;
  logic [N_APP-1:0] starve_ev_w;
  logic [N_APP-1:0] act_w;
  logic             cyc_ev_w;

  // --------------------------------------------------------------------------
  // Per-approach phase trackers
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_APP; i++) begin : g_trk
    logic [1:0] st_q;
    logic [1:0] st_d;
    logic [5:0] dwell_q;
    logic [5:0] dwell_d;
    logic       part_q;     // state was entered straight from UNK
    logic       part_d;
    logic [1:0] smp_st_w;
    logic       legal_w;
    logic [6:0] dwell_x_w;
    logic       enc_ev;
    logic       seq_ev;
    logic       dwl_ev;
    logic       stv_ev;

    // Decode the sample into the tracker state it represents
    always_comb begin
      legal_w  = 1'b1;
      smp_st_w = ST_UNK;
      case (samp_q[i])
        ENC_RED: smp_st_w = ST_RED;
        ENC_YEL: smp_st_w = ST_YEL;
        ENC_GRN: smp_st_w = ST_GRN;
        default: legal_w  = 1'b0;
      endcase
    end

    assign dwell_x_w     = {1'b0, dwell_q};
    assign green_mask[i] = samp_q[i][0];
    assign act_w[i]      = samp_vld_q && ((smp_st_w == ST_GRN) || (smp_st_w == ST_YEL));

    // State register
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q    <= ST_UNK;
        dwell_q <= '0;
        part_q  <= 1'b0;
      end else begin
        st_q    <= st_d;
        dwell_q <= dwell_d;
        part_q  <= part_d;
      end
    end

    // Next-state logic
    always_comb begin
      st_d    = st_q;
      dwell_d = dwell_q;
      part_d  = part_q;
      if (samp_vld_q) begin
        if (!legal_w) begin
          st_d    = ST_UNK;
          dwell_d = '0;
          part_d  = 1'b0;
        end else if (st_q == ST_UNK) begin
          st_d    = smp_st_w;
          dwell_d = 6'd1;
          part_d  = 1'b1;
        end else if (smp_st_w == st_q) begin
          if (dwell_q != DWELL_SAT) begin
            dwell_d = dwell_q + 6'd1;
          end
        end else begin
          // Any value change, legal or not, adopts the new value
          st_d    = smp_st_w;
          dwell_d = 6'd1;
          part_d  = 1'b0;
        end
      end
    end

    // Event outputs
    always_comb begin
      enc_ev = 1'b0;
      seq_ev = 1'b0;
      dwl_ev = 1'b0;
      stv_ev = 1'b0;
      if (samp_vld_q) begin
        if (!legal_w) begin
          enc_ev = 1'b1;
        end else if (st_q != ST_UNK) begin
          if (smp_st_w == st_q) begin
            // Fires only on the increment that reaches the limit, hence once
            // per red interval; a saturated counter never re-fires.
            if ((st_q == ST_RED) && !part_q && (dwell_q != DWELL_SAT) &&
                ((dwell_x_w + 7'd1) == STARVE_AT_C)) begin
              stv_ev = 1'b1;
            end
          end else begin
            case (st_q)
              ST_GRN: begin
                if (smp_st_w != ST_YEL) begin
                  seq_ev = 1'b1;
                end else if (!part_q && (dwell_x_w < MIN_GREEN_C)) begin
                  dwl_ev = 1'b1;
                end
              end
              ST_YEL: begin
                if (smp_st_w != ST_RED) begin
                  seq_ev = 1'b1;
                end else if (!part_q && (dwell_x_w != YEL_CYC_C)) begin
                  dwl_ev = 1'b1;
                end
              end
              default: begin
                if (smp_st_w != ST_GRN) begin
                  seq_ev = 1'b1;
                end
              end
            endcase
          end
        end
      end
    end

    assign enc_ev_w[i]    = enc_ev;
    assign seq_ev_w[i]    = seq_ev;
    assign dwell_ev_w[i]  = dwl_ev;
    assign starve_ev_w[i] = stv_ev;

    // The completed-cycle count follows the R2LandR2D head only; any Y->R
    // counts, including one that also raises a dwell error.
    if (i == N_APP - 1) begin : g_cyc
      assign cyc_ev_w = samp_vld_q && (st_q == ST_YEL) && (smp_st_w == ST_RED);
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags and cycle counter
  // --------------------------------------------------------------------------
  logic [3:0] err_enc_q,    err_enc_d;
  logic [3:0] err_seq_q,    err_seq_d;
  logic [3:0] err_dwell_q,  err_dwell_d;
  logic [3:0] err_starve_q, err_starve_d;
  logic       err_conf_q,   err_conf_d;
  logic [7:0] cycle_cnt_q,  cycle_cnt_d;
  logic       conf_ev_w;

  assign conf_ev_w = (act_w[3] && (|act_w[2:0])) || (act_w[2] && act_w[1]);

  // A violation on the clearing edge is OR-ed in after the clear, so it wins.
  always_comb begin
    err_enc_d    = (clr_err ? 4'b0000 : err_enc_q)    | enc_ev_w;
    err_seq_d    = (clr_err ? 4'b0000 : err_seq_q)    | seq_ev_w;
    err_dwell_d  = (clr_err ? 4'b0000 : err_dwell_q)  | dwell_ev_w;
    err_starve_d = (clr_err ? 4'b0000 : err_starve_q) | starve_ev_w;
    err_conf_d   = (clr_err ? 1'b0    : err_conf_q)   | conf_ev_w;
    cycle_cnt_d  = cycle_cnt_q + {7'd0, cyc_ev_w};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_enc_q    <= '0;
      err_seq_q    <= '0;
      err_dwell_q  <= '0;
      err_starve_q <= '0;
      err_conf_q   <= 1'b0;
      cycle_cnt_q  <= '0;
    end else begin
      err_enc_q    <= err_enc_d;
      err_seq_q    <= err_seq_d;
      err_dwell_q  <= err_dwell_d;
      err_starve_q <= err_starve_d;
      err_conf_q   <= err_conf_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  assign err_enc      = err_enc_q;
  assign err_seq      = err_seq_q;
  assign err_dwell    = err_dwell_q;
  assign err_starve   = err_starve_q;
  assign err_conflict = err_conf_q;
  assign err_any      = (|err_enc_q) | (|err_seq_q) | (|err_dwell_q) |
                        (|err_starve_q) | err_conf_q;
  assign cycle_cnt    = cycle_cnt_q;

endmodule
`default_nettype wire
